// File: rtl/oram_path_bucket_index_gen_if.sv
// Request/response bundle for the path bucket index generator: the walker drives
// Start/Enable/leaf and observes the per-level bucket indices.
interface oram_path_bucket_index_gen_if #(
  parameter int ORAML = 10
) ();
  localparam int LW = $clog2(ORAML) + 1;

  logic               Start;
  logic               Enable;
  logic [ORAML-1:0]   leaf;
  logic [LW-1:0]      currentLevel;
  logic [ORAML:0]     BktIdx;
  logic [ORAML+1:0]   PhyBktIdx;
  logic [ORAML:0]     STIdx;
  logic [ORAML:0]     BktIdxInST;

  modport master (
    output Start, Enable, leaf,
    input  currentLevel, BktIdx, PhyBktIdx, STIdx, BktIdxInST
  );

  modport slave (
    input  Start, Enable, leaf,
    output currentLevel, BktIdx, PhyBktIdx, STIdx, BktIdxInST
  );
endinterface

// File: rtl/oram_path_bucket_index_gen.sv
// Walks one Path ORAM path root-to-leaf, one level per Enable, producing the logical
// heap bucket index and the DRAM-row-aware subtree slot. One-cycle latency, no backpressure.
module oram_path_bucket_index_gen #(
  parameter int ORAML           = 10,
  parameter int DDRROWWidth     = 10,
  parameter int BktSize_DRWords = 8
) (
  input  logic Clock,
  input  logic Reset,
  oram_path_bucket_index_gen_if.slave io
);
  localparam int LW            = $clog2(ORAML) + 1;
  localparam int IW            = ORAML + 1;
  localparam int BucketsPerRow = (1 << DDRROWWidth) / BktSize_DRWords;
  localparam int StRaw         = $clog2(BucketsPerRow + 1) - 1;
  localparam int StMin         = (StRaw < 1) ? 1 : StRaw;
  localparam int STLevel       = (StMin > ORAML + 1) ? ORAML + 1 : StMin;
  localparam int SW            = (STLevel > 1) ? $clog2(STLevel) : 1;
  localparam logic [IW-1:0] ST_FULL = IW'((64'd1 << STLevel) - 64'd1);
  localparam logic [LW-1:0] LVL_IDLE = LW'(ORAML + 1);
  localparam logic [LW-1:0] LVL_LAST = LW'(ORAML);

  logic [LW-1:0]    lvl_q,    lvl_d;
  logic [IW-1:0]    bkt_q,    bkt_d;
  logic [IW-1:0]    st_q,     st_d;
  logic [IW-1:0]    in_st_q,  in_st_d;
  logic [ORAML-1:0] leaf_q,   leaf_d;
  // Depth of the current level inside its subtree, so the wrap test needs no divider.
  logic [SW-1:0]    st_lvl_q, st_lvl_d;

  logic          b;
  logic          wrap;
  logic [IW-1:0] n;
  logic [IW-1:0] st_next;

  always_comb begin
    b = 1'b0;
    for (int i = 0; i < ORAML; i++) begin
      if (lvl_q == LW'(i)) begin
        b = leaf_q[i];
      end
    end
  end

  always_comb begin
    wrap    = (st_lvl_q == SW'(STLevel - 1));
    n       = (in_st_q << 1) + IW'(1) + IW'(b);
    st_next = (st_q << STLevel) + IW'(1) + (n - ST_FULL);

    lvl_d    = lvl_q;
    bkt_d    = bkt_q;
    st_d     = st_q;
    in_st_d  = in_st_q;
    leaf_d   = leaf_q;
    st_lvl_d = st_lvl_q;

    if (io.Start) begin
      leaf_d   = io.leaf;
      lvl_d    = '0;
      bkt_d    = '0;
      st_d     = '0;
      in_st_d  = '0;
      st_lvl_d = '0;
    end else if (io.Enable && (lvl_q <= LVL_LAST)) begin
      lvl_d = lvl_q + LW'(1);
      bkt_d = (bkt_q << 1) + IW'(1) + IW'(b);
      if (wrap) begin
        st_d     = st_next;
        in_st_d  = '0;
        st_lvl_d = '0;
      end else begin
        in_st_d  = n;
        st_lvl_d = st_lvl_q + SW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lvl_q    <= LVL_IDLE;
      bkt_q    <= '0;
      st_q     <= '0;
      in_st_q  <= '0;
      leaf_q   <= '0;
      st_lvl_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      bkt_q    <= bkt_d;
      st_q     <= st_d;
      in_st_q  <= in_st_d;
      leaf_q   <= leaf_d;
      st_lvl_q <= st_lvl_d;
    end
  end

  // Local index never reaches 2^STLevel, so the add is a plain concatenation.
  assign io.currentLevel = lvl_q;
  assign io.BktIdx       = bkt_q;
  assign io.STIdx        = st_q;
  assign io.BktIdxInST   = in_st_q;
  assign io.PhyBktIdx    = ((IW + 1)'(st_q) << STLevel) + (IW + 1)'(in_st_q);

endmodule

// File: tb/tb_oram_path_bucket_index_gen.sv
// Directed bench: small config (ORAML=3, STLevel=2) with hand-computed walks, plus
// default config walks against a subtree-layout reference model.
module tb_oram_path_bucket_index_gen;
  logic Clock = 1'b0;
  logic Reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 Clock = ~Clock;

  oram_path_bucket_index_gen_if #(.ORAML(3))  s_if ();
  oram_path_bucket_index_gen_if #(.ORAML(10)) d_if ();

  oram_path_bucket_index_gen #(.ORAML(3), .DDRROWWidth(4), .BktSize_DRWords(4)) u_small (
    .Clock (Clock),
    .Reset (Reset),
    .io    (s_if)
  );

  oram_path_bucket_index_gen u_dflt (
    .Clock (Clock),
    .Reset (Reset),
    .io    (d_if)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic s_cyc(input logic st, input logic en, input logic [2:0] lf);
    s_if.Start  = st;
    s_if.Enable = en;
    s_if.leaf   = lf;
    @(posedge Clock);
    #1;
    s_if.Start  = 1'b0;
    s_if.Enable = 1'b0;
  endtask

  task automatic d_cyc(input logic st, input logic en, input logic [9:0] lf);
    d_if.Start  = st;
    d_if.Enable = en;
    d_if.leaf   = lf;
    @(posedge Clock);
    #1;
    d_if.Start  = 1'b0;
    d_if.Enable = 1'b0;
  endtask

  // Reference: heap index from path bits; physical slot from breadth-first subtree
  // numbering, each subtree's child chosen by its STL path bits read MSB-first.
  function automatic void model(input int oraml, input int stl, input int lf, input int lvl,
                                output longint bkt, output longint phy);
    longint s, k, loc;
    int r, d, f;
    f   = 1 << stl;
    bkt = 0;
    for (int l = 0; l < lvl; l++) bkt = 2 * bkt + 1 + ((lf >> l) & 1);
    r = lvl / stl;
    d = lvl % stl;
    s = 0;
    for (int j = 0; j < r; j++) begin
      k = 0;
      for (int t = 0; t < stl; t++) k = 2 * k + ((lf >> (j * stl + t)) & 1);
      s = s * f + 1 + k;
    end
    loc = (longint'(1) << d) - 1;
    k = 0;
    for (int t = 0; t < d; t++) k = 2 * k + ((lf >> (r * stl + t)) & 1);
    loc = loc + k;
    phy = (s * f + loc) % (longint'(1) << (oraml + 2));
  endfunction

  task automatic s_walk(input string tag, input logic [2:0] lf, input int eb[4], input int ep[4]);
    s_cyc(1'b1, 1'b0, lf);
    for (int l = 0; l < 4; l++) begin
      chk({tag, "_lvl"}, longint'(s_if.currentLevel), l);
      chk({tag, "_bkt"}, longint'(s_if.BktIdx), eb[l]);
      chk({tag, "_phy"}, longint'(s_if.PhyBktIdx), ep[l]);
      s_cyc(1'b0, 1'b1, 3'b000);
    end
    chk({tag, "_done"}, longint'(s_if.currentLevel), 4);
  endtask

  initial begin
    longint eb, ep;
    longint slot_map [longint];
    logic [9:0] rl;

    s_if.Start = 1'b0; s_if.Enable = 1'b0; s_if.leaf = '0;
    d_if.Start = 1'b0; d_if.Enable = 1'b0; d_if.leaf = '0;

    // Reset wins over Start/Enable
    Reset = 1'b1;
    s_if.Start = 1'b1; s_if.Enable = 1'b1; s_if.leaf = 3'b111;
    d_if.Start = 1'b1; d_if.Enable = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    s_if.Start = 1'b0; s_if.Enable = 1'b0;
    d_if.Start = 1'b0; d_if.Enable = 1'b0;
    chk("rst_lvl", longint'(s_if.currentLevel), 4);
    chk("rst_bkt", longint'(s_if.BktIdx), 0);
    chk("rst_st", longint'(s_if.STIdx), 0);
    chk("rst_inst", longint'(s_if.BktIdxInST), 0);
    chk("rst_phy", longint'(s_if.PhyBktIdx), 0);
    chk("rst_dlvl", longint'(d_if.currentLevel), 11);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("idle_en_lvl", longint'(s_if.currentLevel), 4);
    chk("idle_en_bkt", longint'(s_if.BktIdx), 0);

    // leaf 101: explicit subtree coordinates per level
    s_cyc(1'b1, 1'b0, 3'b101);
    chk("l101_st0", longint'(s_if.STIdx), 0);
    chk("l101_in0", longint'(s_if.BktIdxInST), 0);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("l101_st1", longint'(s_if.STIdx), 0);
    chk("l101_in1", longint'(s_if.BktIdxInST), 2);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("l101_st2", longint'(s_if.STIdx), 3);
    chk("l101_in2", longint'(s_if.BktIdxInST), 0);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("l101_st3", longint'(s_if.STIdx), 3);
    chk("l101_in3", longint'(s_if.BktIdxInST), 2);

    s_walk("l101", 3'b101, '{0, 2, 5, 12}, '{0, 2, 12, 14});
    s_walk("l000", 3'b000, '{0, 1, 3, 7},  '{0, 1, 4, 5});
    s_walk("l111", 3'b111, '{0, 2, 6, 14}, '{0, 2, 16, 18});
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("done_en_lvl", longint'(s_if.currentLevel), 4);

    // Start mid-walk restarts at the root with the new leaf
    s_cyc(1'b1, 1'b0, 3'b101);
    s_cyc(1'b0, 1'b1, 3'b000);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("mid_lvl_before", longint'(s_if.currentLevel), 2);
    s_cyc(1'b1, 1'b1, 3'b011);
    chk("mid_lvl", longint'(s_if.currentLevel), 0);
    chk("mid_phy", longint'(s_if.PhyBktIdx), 0);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("mid_bkt1", longint'(s_if.BktIdx), 2);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("mid_bkt2", longint'(s_if.BktIdx), 6);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("mid_bkt3", longint'(s_if.BktIdx), 13);

    // Enable gaps hold state, then the walk resumes (leaf 110)
    s_cyc(1'b1, 1'b0, 3'b110);
    s_cyc(1'b0, 1'b1, 3'b000);
    for (int g = 0; g < 4; g++) begin
      s_cyc(1'b0, 1'b0, 3'b001);
      chk("gap_lvl", longint'(s_if.currentLevel), 1);
      chk("gap_bkt", longint'(s_if.BktIdx), 1);
      chk("gap_phy", longint'(s_if.PhyBktIdx), 1);
    end
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("gap_bkt2", longint'(s_if.BktIdx), 4);
    chk("gap_phy2", longint'(s_if.PhyBktIdx), 8);
    s_cyc(1'b0, 1'b1, 3'b000);
    chk("gap_bkt3", longint'(s_if.BktIdx), 10);
    chk("gap_phy3", longint'(s_if.PhyBktIdx), 10);

    // All 8 small-config paths: model match and one logical bucket per physical slot
    for (int lf = 0; lf < 8; lf++) begin
      s_cyc(1'b1, 1'b0, 3'(lf));
      for (int l = 0; l < 4; l++) begin
        model(3, 2, lf, l, eb, ep);
        chk("all_bkt", longint'(s_if.BktIdx), eb);
        chk("all_phy", longint'(s_if.PhyBktIdx), ep);
        if (slot_map.exists(ep)) chk("all_slot_unique", slot_map[ep], eb);
        else slot_map[ep] = eb;
        s_cyc(1'b0, 1'b1, 3'b000);
      end
    end

    // Default parameters (STLevel=7): random leaves, full walks
    for (int w = 0; w < 8; w++) begin
      rl = 10'($urandom_range(0, 1023));
      if (w == 0) rl = 10'h3ff;
      d_cyc(1'b1, 1'b0, rl);
      for (int l = 0; l <= 10; l++) begin
        model(10, 7, int'(rl), l, eb, ep);
        chk("dflt_lvl", longint'(d_if.currentLevel), l);
        chk("dflt_bkt", longint'(d_if.BktIdx), eb);
        chk("dflt_phy", longint'(d_if.PhyBktIdx), ep);
        d_cyc(1'b0, 1'b1, 10'd0);
      end
      chk("dflt_done", longint'(d_if.currentLevel), 11);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
